// File: rtl/tt_um_parx_delta_dec.sv
// Running-sum to delta decoder tile: D[n] = S[n] - S[n-1] mod 256, queued in a small FIFO.
// Optional feature: define PARX_DELTA_BYPASS_EN to let uio_in[6] pass sum bytes through unchanged.
module tt_um_parx_delta_dec #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshake: valid (uio_out[1]) is high while uo_out holds the FIFO head; each
  // rising edge on ack (uio_in[2]) consumes that head, and an ack while valid is
  // low is ignored. Producers present a byte on ui_in and raise stb (uio_in[0]).

  // Reset asserts asynchronously but releases only on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_i = rst_sync[1];

  logic [SYNC_STAGES-1:0] stb_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic [SYNC_STAGES-1:0] clr_sync;
  logic                   stb_s;
  logic                   ack_s;
  logic                   clr_s;
  logic                   stb_prev;
  logic                   ack_prev;
  logic                   push_r;
  logic                   pop_r;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      stb_sync <= '0;
      ack_sync <= '0;
      clr_sync <= '0;
      stb_prev <= 1'b0;
      ack_prev <= 1'b0;
      push_r   <= 1'b0;
      pop_r    <= 1'b0;
    end else begin
      stb_sync <= {stb_sync[SYNC_STAGES-2:0], uio_in[0]};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], uio_in[2]};
      clr_sync <= {clr_sync[SYNC_STAGES-2:0], uio_in[5]};
      stb_prev <= stb_s;
      ack_prev <= ack_s;
      push_r   <= stb_s & ~stb_prev;
      pop_r    <= ack_s & ~ack_prev;
    end
  end

  assign stb_s = stb_sync[SYNC_STAGES-1];
  assign ack_s = ack_sync[SYNC_STAGES-1];
  assign clr_s = clr_sync[SYNC_STAGES-1];

`ifdef PARX_DELTA_BYPASS_EN
  logic [SYNC_STAGES-1:0] byp_sync;
  logic                   byp_s;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) byp_sync <= '0;
    else        byp_sync <= {byp_sync[SYNC_STAGES-2:0], uio_in[6]};
  end

  assign byp_s = byp_sync[SYNC_STAGES-1];

  logic unused_pins;
  assign unused_pins = &{1'b0, ena, uio_in[7], uio_in[4:3], uio_in[1]};
`else
  logic unused_pins;
  assign unused_pins = &{1'b0, ena, uio_in[7:6], uio_in[4:3], uio_in[1]};
`endif

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [7:0]       pred;
  logic             ovf;
  logic             full;
  logic             valid;
  logic [7:0]       delta;
  logic             wr_en;
  logic             rd_en;

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_comb begin
    delta = ui_in - pred;
`ifdef PARX_DELTA_BYPASS_EN
    if (byp_s) delta = ui_in;
`endif
  end

  // A pop against a full FIFO frees the slot the simultaneous push lands in.
  assign rd_en = pop_r & valid & ~clr_s;
  assign wr_en = push_r & ~clr_s & (~full | rd_en);

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pred  <= 8'h00;
      ovf   <= 1'b0;
    end else if (clr_s) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      pred  <= 8'h00;
      ovf   <= 1'b0;
    end else begin
      // The predictor follows every sum byte, even dropped ones.
      if (push_r) begin
        pred <= ui_in;
        if (!wr_en) ovf <= 1'b1;
      end
      if (wr_en) begin
        mem[tail] <= delta;
        tail      <= tail + PTR_W'(1);
      end
      if (rd_en) head <= head + PTR_W'(1);
      if (wr_en && !rd_en)      count <= count + CNT_W'(1);
      else if (!wr_en && rd_en) count <= count - CNT_W'(1);
    end
  end

  assign uo_out  = valid ? mem[head] : 8'h00;
  assign uio_out = {3'b000, ovf, full, 1'b0, valid, 1'b0};
  assign uio_oe  = 8'b0001_1010;

endmodule

// File: tb/tb_tt_um_parx_delta_dec.sv
// Directed bench for tt_um_parx_delta_dec: stimulus through pin-level strobes, fixed expected values.
module tb_tt_um_parx_delta_dec;

  localparam int SYNC = 2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic stb, ack, clr, byp;

  int n_tests = 0;
  int n_fail  = 0;

  assign uio_in = {1'b0, byp, clr, 2'b00, ack, 1'b0, stb};

  tt_um_parx_delta_dec #(.DEPTH(4), .SYNC_STAGES(SYNC)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // drivers: each strobe edge is visible on the outputs SYNC+2 edges later
  task automatic push(input logic [7:0] s);
    ui_in = s;
    stb   = 1'b1;
    tick(SYNC + 2);
    stb   = 1'b0;
    tick(SYNC + 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(SYNC + 2);
    ack = 1'b0;
    tick(SYNC + 1);
  endtask

  task automatic push_ack(input logic [7:0] s);
    ui_in = s;
    stb   = 1'b1;
    ack   = 1'b1;
    tick(SYNC + 2);
    stb   = 1'b0;
    ack   = 1'b0;
    tick(SYNC + 1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(SYNC + 2);
    clr = 1'b0;
    tick(SYNC + 2);
  endtask

  function automatic logic [7:0] valid_b();
    return {7'b0, uio_out[1]};
  endfunction
  function automatic logic [7:0] full_b();
    return {7'b0, uio_out[3]};
  endfunction
  function automatic logic [7:0] ovf_b();
    return {7'b0, uio_out[4]};
  endfunction

  initial begin
    ena = 1'b1; ui_in = 8'h00;
    stb = 1'b0; ack = 1'b0; clr = 1'b0; byp = 1'b0;
    rst_n = 1'b0;
    tick(3);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'h1A);
    rst_n = 1'b1;
    tick(4);

    // basic decode, one ack per sample
    push(8'h05);  check("t1_d0", uo_out, 8'h05); check("t1_v0", valid_b(), 8'h01);
    do_ack();
    push(8'h0C);  check("t1_d1", uo_out, 8'h07);
    do_ack();
    push(8'h0C);  check("t1_d2", uo_out, 8'h00); check("t1_v2", valid_b(), 8'h01);
    do_ack();
    check("t1_empty", valid_b(), 8'h00);
    check("t1_ovf", ovf_b(), 8'h00);
    check("t1_uo_empty", uo_out, 8'h00);

    // wrap-around subtraction from a cleared predictor
    pulse_clr();
    push(8'hFE);
    push(8'h02);
    check("t2_d0", uo_out, 8'hFE);
    do_ack();
    check("t2_d1", uo_out, 8'h04);
    do_ack();

    // overflow: fifth push dropped, predictor still tracks it
    push(8'h10); push(8'h20); push(8'h30);
    check("t3_notfull", full_b(), 8'h00);
    push(8'h40);
    check("t3_full", full_b(), 8'h01);
    check("t3_ovf0", ovf_b(), 8'h00);
    push(8'h1A);
    check("t3_ovf1", ovf_b(), 8'h01);
    check("t3_h0", uo_out, 8'h0E); do_ack();
    check("t3_h1", uo_out, 8'h10); do_ack();
    check("t3_h2", uo_out, 8'h10); do_ack();
    check("t3_h3", uo_out, 8'h10); do_ack();
    check("t3_drained", valid_b(), 8'h00);
    push(8'h20);
    check("t3_after_drop", uo_out, 8'h06);
    check("t3_ovf_sticky", ovf_b(), 8'h01);
    do_ack();

    // simultaneous push and pop, full then empty
    pulse_clr();
    check("t4_clr_ovf", ovf_b(), 8'h00);
    push(8'h21); push(8'h23); push(8'h26); push(8'h2A);
    check("t4_full", full_b(), 8'h01);
    push_ack(8'h30);
    check("t4_still_full", full_b(), 8'h01);
    check("t4_ovf", ovf_b(), 8'h00);
    check("t4_head_adv", uo_out, 8'h02);
    do_ack(); check("t4_h1", uo_out, 8'h03);
    do_ack(); check("t4_h2", uo_out, 8'h04);
    do_ack(); check("t4_h3", uo_out, 8'h06);
    do_ack(); check("t4_empty", valid_b(), 8'h00);
    do_ack(); check("t4_pop_empty_ovf", ovf_b(), 8'h00);
    push_ack(8'h31);
    check("t4_empty_both_v", valid_b(), 8'h01);
    check("t4_empty_both_d", uo_out, 8'h01);
    do_ack();

    // clr mid-stream, then async reset mid-stream
    push(8'h40); push(8'h41);
    check("t5_pre_clr", uo_out, 8'h0F);
    pulse_clr();
    check("t5_clr_v", valid_b(), 8'h00);
    check("t5_clr_ovf", ovf_b(), 8'h00);
    push(8'h30);
    check("t5_first", uo_out, 8'h30);
    push(8'h38); push(8'h3C);
    check("t5_three", valid_b(), 8'h01);
    rst_n = 1'b0;
    #2;
    check("t5_arst_uo", uo_out, 8'h00);
    check("t5_arst_uio", uio_out, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check("t5_post_v", valid_b(), 8'h00);
    push(8'h07);
    check("t5_post_first", uo_out, 8'h07);
    do_ack();

    // bypass pin: pass-through when built in, ignored otherwise
    pulse_clr();
    byp = 1'b1;
    tick(SYNC + 2);
    push(8'h10); push(8'h18);
`ifdef PARX_DELTA_BYPASS_EN
    check("t6_b0", uo_out, 8'h10); do_ack();
    check("t6_b1", uo_out, 8'h18); do_ack();
    byp = 1'b0;
    tick(SYNC + 2);
    push(8'h1B);
    check("t6_b2", uo_out, 8'h03); do_ack();
`else
    check("t6_i0", uo_out, 8'h10); do_ack();
    check("t6_i1", uo_out, 8'h08); do_ack();
    byp = 1'b0;
    tick(SYNC + 2);
    push(8'h1B);
    check("t6_i2", uo_out, 8'h03); do_ack();
`endif
    check("t6_empty", valid_b(), 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
